// File: rtl/csr_uart_tx.sv
// CSR-mapped UART transmitter: data/control/status CSRs, circular TX FIFO and a
// start/data/parity/stop serialiser with a per-frame latched baud divisor.
module csr_uart_tx #(
  parameter int unsigned DataBits   = 8,
  parameter int unsigned Depth      = 8,
  parameter int unsigned PrescWidth = 16,
  parameter logic [11:0] DataAddr   = 12'h050,
  parameter logic [11:0] CtrlAddr   = 12'h051,
  parameter logic [11:0] StatusAddr = 12'h052
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic        csr_enable,
  input  logic [11:0] csr_addr,
  input  logic [2:0]  csr_op,
  input  logic [4:0]  rs1_zimm,
  input  logic [31:0] rs1_data,
  output logic [31:0] csr_out,
  output logic        tx,
  output logic        idle_irq
);

  localparam int unsigned AW = $clog2(Depth);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [2:0] {
    ST_IDLE, ST_LOAD, ST_START, ST_DATA, ST_PARITY, ST_STOP
  } state_t;

  state_t state, state_next;

  logic [DataBits-1:0]   mem [Depth];
  logic [CW-1:0]         wptr, rptr, count;
  logic                  empty, full, ovf;
  logic [PrescWidth-1:0] presc, f_presc, bit_cnt;
  logic                  stop2, par_en, par_odd;
  logic                  f_stop2, f_par_en, par_bit, stop_idx;
  logic [DataBits-1:0]   shifter;
  logic [3:0]            bit_idx;
  logic                  bit_done, more, pop, push_req, push_ok;
  logic [31:0]           wval, ctrl_word, ctrl_new, status_word;
  logic                  wr_en, ctrl_wr;
  logic                  unused_bits;

  // CSR write decode; funct3 encoding: bit 2 selects the immediate form
  assign wval     = csr_op[2] ? {27'b0, rs1_zimm} : rs1_data;
  assign wr_en    = csr_enable && (csr_op[1:0] != 2'b00) && !(csr_op[1] && (rs1_zimm == 5'd0));
  assign ctrl_wr  = wr_en && (csr_addr == CtrlAddr);
  assign push_req = csr_enable && (csr_addr == DataAddr) && (csr_op[1:0] == 2'b01);

  assign count = wptr - rptr;
  assign empty = (count == '0);
  assign full  = (count == CW'(Depth));
  assign pop   = (state == ST_LOAD);
  assign push_ok = push_req && (!full || pop);
  assign more  = !empty || push_ok;
  assign bit_done = (bit_cnt == '0);

  always_comb begin
    ctrl_word = '0;
    ctrl_word[PrescWidth-1:0] = presc;
    ctrl_word[16] = stop2;
    ctrl_word[17] = par_en;
    ctrl_word[18] = par_odd;
    unique case (csr_op[1:0])
      2'b01:   ctrl_new = wval;
      2'b10:   ctrl_new = ctrl_word | wval;
      2'b11:   ctrl_new = ctrl_word & ~wval;
      default: ctrl_new = ctrl_word;
    endcase
    status_word = '0;
    status_word[0] = empty;
    status_word[1] = full;
    status_word[2] = (state != ST_IDLE);
    status_word[3] = ovf;
    status_word[8 +: CW] = count;
    if (csr_addr == CtrlAddr)        csr_out = ctrl_word;
    else if (csr_addr == StatusAddr) csr_out = status_word;
    else                             csr_out = '0;
  end

  assign unused_bits = ^ctrl_new[31:19];

  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wptr[AW-1:0]] <= wval[DataBits-1:0];
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) state <= ST_IDLE;
    else           state <= state_next;
  end

  // A push in the current cycle counts as non-empty so LOAD follows the push directly
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:   if (more) state_next = ST_LOAD;
      ST_LOAD:   state_next = ST_START;
      ST_START:  if (bit_done) state_next = ST_DATA;
      ST_DATA:   if (bit_done && bit_idx == 4'(DataBits - 1))
                   state_next = f_par_en ? ST_PARITY : ST_STOP;
      ST_PARITY: if (bit_done) state_next = ST_STOP;
      ST_STOP:   if (bit_done && (stop_idx || !f_stop2))
                   state_next = more ? ST_LOAD : ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    unique case (state)
      ST_START:  tx = 1'b0;
      ST_DATA:   tx = shifter[0];
      ST_PARITY: tx = par_bit;
      default:   tx = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      wptr <= '0; rptr <= '0; ovf <= 1'b0;
      presc <= '0; stop2 <= 1'b0; par_en <= 1'b0; par_odd <= 1'b0;
      f_presc <= '0; f_stop2 <= 1'b0; f_par_en <= 1'b0; par_bit <= 1'b0;
      bit_cnt <= '0; bit_idx <= '0; stop_idx <= 1'b0; shifter <= '0;
      idle_irq <= 1'b0;
    end else begin
      idle_irq <= (state == ST_STOP) && (state_next == ST_IDLE);
      if (push_ok) wptr <= wptr + 1'b1;
      if (ctrl_wr) begin
        presc   <= ctrl_new[PrescWidth-1:0];
        stop2   <= ctrl_new[16];
        par_en  <= ctrl_new[17];
        par_odd <= ctrl_new[18];
        ovf     <= 1'b0;
      end else if (push_req && !push_ok) begin
        ovf <= 1'b1;
      end
      if (state == ST_LOAD) begin
        rptr     <= rptr + 1'b1;
        shifter  <= mem[rptr[AW-1:0]];
        par_bit  <= (^mem[rptr[AW-1:0]]) ^ par_odd;
        f_presc  <= presc;
        f_stop2  <= stop2;
        f_par_en <= par_en;
        bit_cnt  <= presc;
        bit_idx  <= '0;
        stop_idx <= 1'b0;
      end else if (state != ST_IDLE) begin
        if (bit_done) begin
          bit_cnt <= f_presc;
          if (state == ST_DATA) begin
            shifter <= shifter >> 1;
            bit_idx <= bit_idx + 1'b1;
          end
          if (state == ST_STOP) stop_idx <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt - 1'b1;
        end
      end
    end
  end

endmodule
